// File: rtl/position_pkg.sv
// Shared definitions for the position integrators: state encoding, default widths
// and a width-generic signed add with optional saturation.
package position_pkg;

    localparam int A_W_DEF   = 16;
    localparam int DT_W_DEF  = 16;
    localparam int ACC_W_DEF = 32;
    localparam int SAT_W     = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2
    } state_e;

    typedef struct packed {
        logic              ovf;
        logic signed [SAT_W-1:0] val;
    } sat_res_t;

    // Operands arrive sign-extended from w bits (w <= 62), so the 64-bit sum is exact
    // and overflow is judged against the w-bit signed range.
    function automatic sat_res_t sat_add(
        input logic signed [SAT_W-1:0] x,
        input logic signed [SAT_W-1:0] y,
        input int unsigned             w,
        input logic                    sat_en
    );
        sat_res_t                r;
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] lim;
        sum   = x + y;
        lim   = 64'sd1 <<< (w - 1);
        r.ovf = (sum >= lim) || (sum < -lim);
        r.val = sum;
        if (sat_en && r.ovf) begin
            r.val = sum[SAT_W-1] ? -lim : lim - 64'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_mul_su.sv
// Bit-serial signed x unsigned shift-add multiplier; one multiplier bit per cycle.
// Operands must stay stable while busy; start clears the product and restarts.
module serial_mul_su #(
    parameter int A_W  = 16,
    parameter int DT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [A_W-1:0]    a,
    input  logic        [DT_W-1:0]   b,
    output logic                     busy,
    output logic                     last,
    output logic signed [A_W+DT_W-1:0] prod
);

    localparam int P_W   = A_W + DT_W;
    localparam int BIT_W = (DT_W > 1) ? $clog2(DT_W) : 1;

    logic                    busy_q, busy_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic signed [P_W-1:0]   prod_q, prod_d;
    logic signed [P_W-1:0]   addend;

    assign last = busy_q && (bit_q == BIT_W'(DT_W - 1));

    always_comb begin
        busy_d = busy_q;
        bit_d  = bit_q;
        prod_d = prod_q;
        addend = P_W'(a) <<< bit_q;
        if (start) begin
            busy_d = 1'b1;
            bit_d  = '0;
            prod_d = '0;
        end else if (busy_q) begin
            if (b[bit_q]) begin
                prod_d = prod_q + addend;
            end
            bit_d = bit_q + BIT_W'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            bit_q  <= '0;
            prod_q <= '0;
        end else begin
            busy_q <= busy_d;
            bit_q  <= bit_d;
            prod_q <= prod_d;
        end
    end

    assign busy = busy_q;
    assign prod = prod_q;

endmodule

// File: rtl/multi_axis_integrator.sv
// N-channel rate integrator: acc[ch] += a[ch]*dt using one shared serial multiplier.
// Define MULTI_AXIS_INTEG_SATURATE_EN to clamp on overflow instead of wrapping.
//
// state | meaning
// IDLE  | waiting; clr zeroes accumulators, enable latches a/dt and starts channel 0
// MUL   | serial multiply of channel ch, DT_W cycles
// ACC   | add product into v[ch]; next channel or finish with done
module multi_axis_integrator
    import position_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int A_W   = A_W_DEF,
    parameter int DT_W  = DT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*A_W-1:0]     a,
    input  logic [DT_W-1:0]        dt,
    input  logic                   enable,
    input  logic                   clr,
    output logic [NCH*ACC_W-1:0]   v,
    output logic                   busy,
    output logic                   done,
    output logic [NCH-1:0]         ovf
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int P_W  = A_W + DT_W;

`ifdef MULTI_AXIS_INTEG_SATURATE_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    state_e                 state_q, state_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [NCH*A_W-1:0]     a_l_q, a_l_d;
    logic [DT_W-1:0]        dt_l_q, dt_l_d;
    logic [NCH*ACC_W-1:0]   v_q, v_d;
    logic [NCH-1:0]         ovf_q, ovf_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic                   mul_start;
    logic                   mul_busy;
    logic                   mul_last;
    logic signed [A_W-1:0]  a_sel;
    logic signed [P_W-1:0]  prod;
    logic signed [ACC_W-1:0] v_sel;
    sat_res_t               acc_res;
    logic [ACC_W-1:0]       acc_val;

    assign a_sel = a_l_q[ch_q*A_W +: A_W];
    assign v_sel = v_q[ch_q*ACC_W +: ACC_W];

    serial_mul_su #(
        .A_W  (A_W),
        .DT_W (DT_W)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (a_sel),
        .b     (dt_l_q),
        .busy  (mul_busy),
        .last  (mul_last),
        .prod  (prod)
    );

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        a_l_d     = a_l_q;
        dt_l_d    = dt_l_q;
        v_d       = v_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        mul_start = 1'b0;
        acc_res   = sat_add(SAT_W'(v_sel), SAT_W'(prod), ACC_W, SAT_EN);
        acc_val   = ACC_W'(acc_res.val);

        case (state_q)
            IDLE: begin
                if (clr) begin
                    v_d   = '0;
                    ovf_d = '0;
                end else if (enable) begin
                    a_l_d     = a;
                    dt_l_d    = dt;
                    ch_d      = '0;
                    mul_start = 1'b1;
                    state_d   = MUL;
                end
            end
            MUL: begin
                if (mul_busy && mul_last) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                for (int k = 0; k < NCH; k++) begin
                    if (CH_W'(k) == ch_q) begin
                        v_d[k*ACC_W +: ACC_W] = acc_val;
                        if (acc_res.ovf) begin
                            ovf_d[k] = 1'b1;
                        end
                    end
                end
                if (ch_q == CH_W'(NCH - 1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    ch_d      = ch_q + CH_W'(1);
                    mul_start = 1'b1;
                    state_d   = MUL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            a_l_q   <= '0;
            dt_l_q  <= '0;
            v_q     <= '0;
            ovf_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            a_l_q   <= a_l_d;
            dt_l_q  <= dt_l_d;
            v_q     <= v_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign v    = v_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_multi_axis_integrator.sv
// Directed bench for multi_axis_integrator at default parameters (NCH=2, 16/16/32).
module tb_multi_axis_integrator;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [15:0] dt;
    logic        enable;
    logic        clr;
    logic [63:0] v;
    logic        busy;
    logic        done;
    logic [1:0]  ovf;

    int total = 0;
    int bad   = 0;
    int cyc;
    int early;

    always #5 clk = ~clk;

    multi_axis_integrator dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .dt     (dt),
        .enable (enable),
        .clr    (clr),
        .v      (v),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] dt_i);
        @(negedge clk);
        a      = {a1, a0};
        dt     = dt_i;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    // Called 1 time unit after the start edge; follows the run to its end.
    task automatic run(input string tag, input int disturb, input logic exp_next_busy);
        check({tag, " busy_rise"}, busy, 1);
        cyc   = 0;
        early = 0;
        while (busy === 1'b1 && cyc < 200) begin
            if (done === 1'b1) early++;
            if (disturb >= 0 && cyc == disturb) begin
                a      = ~a;
                dt     = 16'd999;
                enable = 1'b1;
                clr    = 1'b1;
            end else if (disturb >= 0 && cyc == disturb + 1) begin
                enable = 1'b0;
                clr    = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " busy_len"}, cyc, 34);
        check({tag, " early_done"}, early, 0);
        check({tag, " done"}, done, 1);
        @(posedge clk);
        #1;
        check({tag, " done_once"}, done, 0);
        check({tag, " next_busy"}, busy, exp_next_busy);
    endtask

    initial begin
        rst    = 1'b1;
        a      = '0;
        dt     = '0;
        enable = 1'b0;
        clr    = 1'b0;
        #12;
        check("rst v", v, 64'd0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        go(16'd1, 16'd0, 16'd8835);
        run("r1", -1, 1'b0);
        check("r1 v", v, {32'd0, 32'd8835});
        check("r1 ovf", ovf, 0);

        go(16'd1, 16'd0, 16'd8835);
        run("r2", -1, 1'b0);
        check("r2 v", v, {32'd0, 32'd17670});

        go(16'hFFFF, 16'd0, 16'd8835);
        run("r3", -1, 1'b0);
        check("r3 v", v, {32'd0, 32'd8835});

        go(16'd0, 16'hFFFD, 16'd100);
        run("r4", -1, 1'b0);
        check("r4 v", v, {32'hFFFF_FED4, 32'd8835});
        check("r4 ovf", ovf, 0);

        @(negedge clk);
        clr    = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        clr    = 1'b0;
        enable = 1'b0;
        check("clr_en busy", busy, 0);
        check("clr_en v", v, 64'd0);
        @(posedge clk);
        #1;
        check("clr_en busy2", busy, 0);
        check("clr_en done", done, 0);

        go(16'h7FFF, 16'd0, 16'hFFFF);
        run("big1", -1, 1'b0);
        check("big1 v", v, {32'd0, 32'h7FFE_8001});
        check("big1 ovf", ovf, 2'b00);

        go(16'h7FFF, 16'd0, 16'hFFFF);
        run("big2", -1, 1'b0);
        check("big2 ovf", ovf, 2'b01);
`ifdef MULTI_AXIS_INTEG_SATURATE_EN
        check("big2 v", v, {32'd0, 32'h7FFF_FFFF});
`else
        check("big2 v", v, {32'd0, 32'hFFFD_0002});
`endif

        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr v", v, 64'd0);
        check("clr ovf", ovf, 0);

        go(16'd5, 16'd7, 16'd3);
        run("dist", 5, 1'b0);
        check("dist v", v, {32'd21, 32'd15});
        check("dist ovf", ovf, 0);

        go(16'd2, 16'd3, 16'd10);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst v", v, 64'd0);
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        go(16'd2, 16'd3, 16'd10);
        run("post", -1, 1'b0);
        check("post v", v, {32'd30, 32'd20});

        go(16'd9, 16'd9, 16'd0);
        run("dt0", -1, 1'b0);
        check("dt0 v", v, {32'd30, 32'd20});

        @(negedge clk);
        a      = {16'd1, 16'd1};
        dt     = 16'd1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        run("hold1", -1, 1'b1);
        enable = 1'b0;
        run("hold2", -1, 1'b0);
        check("hold v", v, {32'd32, 32'd22});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
